// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-hot column drive, classifies each
// full scan frame, debounces single-key presses/releases and buffers one key.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  input  logic       key_ack,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       overrun
);

  localparam int unsigned DW_W  = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DW_W-1:0]  dwell_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       acc_cnt_q;
  logic [3:0]       acc_code_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, rcnt_q;
  logic [3:0]       cand_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q, key_held_q, overrun_q;

  logic             sample_d, frame_end_d;
  logic [1:0]       cur_cnt_d, cur_row_d, frame_cnt_d;
  logic [2:0]       sum_d;
  logic [3:0]       frame_code_d;
  logic             single_d, accept_d;

  assign col       = 4'b0001 << col_idx_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

  // NOTE: every register below uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '0;
      row_sync_q <= '0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q   <= '0;
      col_idx_q <= 2'd0;
    end else if (sample_d) begin
      dwell_q   <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      dwell_q   <= dwell_q + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sample_d    = (dwell_q == DW_W'(SCAN_DIV - 1));
    frame_end_d = sample_d && (col_idx_q == 2'd3);
    cur_cnt_d   = ($countones(row_sync_q) > 1) ? 2'd2 : 2'($countones(row_sync_q));
    cur_row_d   = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_sync_q[r]) cur_row_d = 2'(r);
    end
    sum_d        = {1'b0, acc_cnt_q} + {1'b0, cur_cnt_d};
    frame_cnt_d  = (sum_d >= 3'd2) ? 2'd2 : sum_d[1:0];
    frame_code_d = (acc_cnt_q != 2'd0) ? acc_code_q : {col_idx_q, cur_row_d};
    single_d     = (frame_cnt_d == 2'd1);
    accept_d     = frame_end_d && single_d &&
                   (((state_q == IDLE) && (DEBOUNCE_N == 1)) ||
                    ((state_q == PRESS_DB) && (frame_code_d == cand_q) &&
                     ((cnt_q + 1'b1) == CNT_W'(DEBOUNCE_N))));
  end

  // Per-frame key tally; the last column's sample is folded in combinationally.
  always_ff @(posedge clk) begin
    if (rst || frame_end_d) begin
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
    end else if (sample_d) begin
      acc_cnt_q  <= frame_cnt_d;
      acc_code_q <= frame_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_end_d) begin
        unique case (state_q)
          IDLE: if (single_d) begin
            if (DEBOUNCE_N == 1) begin
              state_q    <= HELD;
              key_held_q <= 1'b1;
            end else begin
              state_q <= PRESS_DB;
              cand_q  <= frame_code_d;
              cnt_q   <= CNT_W'(1);
            end
          end
          PRESS_DB: if (single_d && (frame_code_d == cand_q)) begin
            if ((cnt_q + 1'b1) == CNT_W'(DEBOUNCE_N)) begin
              state_q    <= HELD;
              cnt_q      <= '0;
              key_held_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
          HELD: if (!single_d) begin
            if (DEBOUNCE_N == 1) begin
              state_q    <= IDLE;
              key_held_q <= 1'b0;
            end else begin
              state_q <= REL_DB;
              rcnt_q  <= CNT_W'(1);
            end
          end
          REL_DB: if (!single_d) begin
            if ((rcnt_q + 1'b1) == CNT_W'(DEBOUNCE_N)) begin
              state_q    <= IDLE;
              rcnt_q     <= '0;
              key_held_q <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end else begin
            state_q <= HELD;
            rcnt_q  <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end

      // One-entry buffer: an ack in the accept cycle frees the slot for the new key.
      if (accept_d) begin
        if (!key_valid_q || key_ack) begin
          key_code_q  <= frame_code_d;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_ack) begin
        key_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_N=2 (16-cycle frame);
// the keypad is modelled combinationally from the column drive.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic        key_ack;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] keys;
    logic        ack;
    int          n;
    logic [3:0]  code;
    logic        valid;
    logic        held;
    logic        ovr;
  } vec_t;

  vec_t vecs[21];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .key_ack   (key_ack),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Key code k = c*4 + r closes row r while column c is driven.
  always_comb begin
    row = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (col[c] && keys[c*4 + r]) row[r] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench #1 after the first edge of cycle 0 (col=0001, dwell=0).
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] code,
                               input logic valid, input logic held, input logic ovr);
    check({tag, " key_code"},  key_code,         code);
    check({tag, " key_valid"}, {3'b0, key_valid}, {3'b0, valid});
    check({tag, " key_held"},  {3'b0, key_held},  {3'b0, held});
    check({tag, " overrun"},   {3'b0, overrun},   {3'b0, ovr});
  endtask

  initial begin
    rst     = 1'b1;
    key_ack = 1'b0;
    keys    = 16'h0000;

    // Cycle counts are relative to reset release; frame f ends in cycle 15+16f.
    vecs[0]  = '{16'h0200, 1'b0, 31, 4'd0,  1'b0, 1'b0, 1'b0}; // key 9, one frame debounced
    vecs[1]  = '{16'h0200, 1'b0,  1, 4'd9,  1'b1, 1'b1, 1'b0}; // accepted after 2nd frame end
    vecs[2]  = '{16'h0000, 1'b0, 31, 4'd9,  1'b1, 1'b1, 1'b0}; // release debouncing
    vecs[3]  = '{16'h0000, 1'b0,  1, 4'd9,  1'b1, 1'b0, 1'b0}; // release accepted
    vecs[4]  = '{16'h0000, 1'b1,  1, 4'd9,  1'b0, 1'b0, 1'b0}; // ack clears valid
    vecs[5]  = '{16'h0008, 1'b0, 15, 4'd9,  1'b0, 1'b0, 1'b0}; // key 3 for a single frame
    vecs[6]  = '{16'h0000, 1'b0, 32, 4'd9,  1'b0, 1'b0, 1'b0}; // glitch rejected
    vecs[7]  = '{16'h4010, 1'b0, 64, 4'd9,  1'b0, 1'b0, 1'b0}; // keys 4+14 ghosting
    vecs[8]  = '{16'h0040, 1'b0, 32, 4'd6,  1'b1, 1'b1, 1'b0}; // key 6 accepted
    vecs[9]  = '{16'h0000, 1'b0, 32, 4'd6,  1'b1, 1'b0, 1'b0}; // release, no ack
    vecs[10] = '{16'h8000, 1'b0, 31, 4'd6,  1'b1, 1'b0, 1'b0}; // key 15 in its accept cycle
    vecs[11] = '{16'h8000, 1'b1,  1, 4'd15, 1'b1, 1'b1, 1'b0}; // ack + accept: loads, no overrun
    vecs[12] = '{16'h0000, 1'b0, 32, 4'd15, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{16'h0000, 1'b1,  1, 4'd15, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16'h0020, 1'b0, 31, 4'd5,  1'b1, 1'b1, 1'b0}; // key 5 accepted
    vecs[15] = '{16'h0000, 1'b0, 32, 4'd5,  1'b1, 1'b0, 1'b0};
    vecs[16] = '{16'h1000, 1'b0, 31, 4'd5,  1'b1, 1'b0, 1'b0}; // key 12 about to accept
    vecs[17] = '{16'h1000, 1'b0,  1, 4'd5,  1'b1, 1'b1, 1'b1}; // dropped, overrun set
    vecs[18] = '{16'h1000, 1'b1,  1, 4'd5,  1'b0, 1'b1, 1'b1}; // ack clears valid only
    vecs[19] = '{16'h0000, 1'b0, 32, 4'd5,  1'b0, 1'b0, 1'b1}; // overrun sticky
    vecs[20] = '{16'h0000, 1'b1,  1, 4'd5,  1'b0, 1'b0, 1'b1}; // ack with no key ignored

    // Column rotation and flags out of reset.
    do_reset();
    check_outputs("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    for (int cyc = 0; cyc <= 16; cyc++) begin
      logic [3:0] exp_col;
      exp_col = 4'b0001 << ((cyc / 4) % 4);
      check($sformatf("col cycle %0d", cyc), col, exp_col);
      tick(1);
    end

    do_reset();
    for (int i = 0; i < 21; i++) begin
      keys    = vecs[i].keys;
      key_ack = vecs[i].ack;
      tick(vecs[i].n);
      key_ack = 1'b0;
      check_outputs($sformatf("vec %0d", i), vecs[i].code, vecs[i].valid,
                    vecs[i].held, vecs[i].ovr);
    end

    // Reset in the middle of debouncing key 7, key kept pressed throughout.
    do_reset();
    keys = 16'h0080;
    tick(20);
    check_outputs("key7 press_db", 4'd0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("key7 reset col", col, 4'b0001);
    check_outputs("key7 reset", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(31);
    check_outputs("key7 pre-accept", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outputs("key7 accepted", 4'd7, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
